// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine: state encoding, FIFO entry
// layout and small constant helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRKWAIT
    } rx_state_t;

    localparam int unsigned ENTRY_W    = 11;
    localparam int unsigned E_DATA_LSB = 0;
    localparam int unsigned E_DATA_MSB = 7;
    localparam int unsigned E_PERR     = 8;
    localparam int unsigned E_FERR     = 9;
    localparam int unsigned E_BRK      = 10;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic       brk,
        input logic       ferr,
        input logic       perr,
        input logic [7:0] data
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[E_DATA_MSB:E_DATA_LSB] = data;
        e[E_PERR] = perr;
        e[E_FERR] = ferr;
        e[E_BRK]  = brk;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; a pop in the same cycle frees room for a push
// into a full FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNT_W-1:0]   o_count
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_engine.sv
// UART receive engine: start validation, mid-bit sampling, parity/framing/break
// checks and a receive FIFO towards the processor read port.
module uart_rx_fifo_engine
    import uart_pkg::*;
#(
    parameter int unsigned K_W        = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [K_W-1:0]   K,
    input  logic [K_W-1:0]   K_2,
    input  logic             RX_in,
    input  logic             EIGHT,
    input  logic             PEN,
    input  logic             OHEL,
    input  logic             TWO_STOP,
    input  logic             READS,
    output logic [7:0]       UART_RDATA,
    output logic             RXRDY,
    output logic             PERR,
    output logic             FERR,
    output logic             BRK,
    output logic             OVF,
    output logic [CNT_W-1:0] FIFO_COUNT
);

    rx_state_t          r_state;
    logic               r_sync1;
    logic               r_rxs;
    logic               r_rxs_d;
    logic [K_W-1:0]     r_cnt;
    logic [2:0]         r_bitidx;
    logic [7:0]         r_data;
    logic               r_pbit;
    logic               r_stop1;
    logic               r_cfg_eight;
    logic               r_cfg_pen;
    logic               r_cfg_odd;
    logic               r_cfg_two;
    logic               r_push;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_ovf;

    logic [K_W-1:0]     w_k_load;
    logic [K_W-1:0]     w_k2_load;
    logic               w_btu;
    logic [2:0]         w_last_idx;
    logic               w_perr;
    logic               w_brk_zero;
    logic               w_brk1;
    logic               w_brk2;
    logic               w_ferr2;
    logic [ENTRY_W-1:0] w_rdata;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_overrun;

    // A zero bit-time constant counts as one clock per bit.
    assign w_k_load   = (K == '0)   ? '0 : K - 1'b1;
    assign w_k2_load  = (K_2 == '0) ? '0 : K_2 - 1'b1;
    assign w_btu      = (r_cnt == '0);
    assign w_last_idx = r_cfg_eight ? 3'd7 : 3'd6;

    assign w_perr     = r_cfg_pen & (^r_data ^ r_pbit ^ r_cfg_odd);
    assign w_brk_zero = (r_data == '0) & (~r_cfg_pen | ~r_pbit);
    assign w_brk1     = w_brk_zero & ~r_rxs;
    assign w_brk2     = w_brk_zero & ~r_stop1;
    assign w_ferr2    = ~r_stop1 | ~r_rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b1;
            r_rxs       <= 1'b1;
            r_rxs_d     <= 1'b1;
            r_cnt       <= '0;
            r_bitidx    <= '0;
            r_data      <= '0;
            r_pbit      <= 1'b0;
            r_stop1     <= 1'b0;
            r_cfg_eight <= 1'b0;
            r_cfg_pen   <= 1'b0;
            r_cfg_odd   <= 1'b0;
            r_cfg_two   <= 1'b0;
            r_push      <= 1'b0;
            r_entry     <= '0;
        end else begin
            r_sync1 <= RX_in;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
            r_push  <= 1'b0;
            // Every non-START interval is a full bit, so the BTU reload is always K-1.
            r_cnt   <= w_btu ? w_k_load : r_cnt - 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (r_rxs_d & ~r_rxs) begin
                        r_state     <= START;
                        r_cnt       <= w_k2_load;
                        r_data      <= '0;
                        r_bitidx    <= '0;
                        r_cfg_eight <= EIGHT;
                        r_cfg_pen   <= PEN;
                        r_cfg_odd   <= OHEL;
                        r_cfg_two   <= TWO_STOP;
                    end
                end
                START: begin
                    if (w_btu) r_state <= r_rxs ? IDLE : DATA;
                end
                DATA: begin
                    if (w_btu) begin
                        r_data[r_bitidx] <= r_rxs;
                        if (r_bitidx == w_last_idx) r_state <= r_cfg_pen ? PARITY : STOP1;
                        else                        r_bitidx <= r_bitidx + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_btu) begin
                        r_pbit  <= r_rxs;
                        r_state <= STOP1;
                    end
                end
                STOP1: begin
                    if (w_btu) begin
                        if (r_cfg_two) begin
                            r_stop1 <= r_rxs;
                            r_state <= STOP2;
                        end else begin
                            r_push  <= 1'b1;
                            r_entry <= pack_entry(w_brk1, ~r_rxs, w_perr, r_data);
                            r_state <= w_brk1 ? BRKWAIT : IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (w_btu) begin
                        r_push  <= 1'b1;
                        r_entry <= pack_entry(w_brk2, w_ferr2, w_perr, r_data);
                        r_state <= w_brk2 ? BRKWAIT : IDLE;
                    end
                end
                BRKWAIT: begin
                    if (r_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push),
        .i_wdata (r_entry),
        .i_pop   (READS),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A full FIFO with a coincident read accepts the frame, so no overrun then.
    assign w_overrun = r_push & w_full & ~READS;

    always_ff @(posedge clk) begin
        if (reset)          r_ovf <= 1'b0;
        else if (w_overrun) r_ovf <= 1'b1;
        else if (READS)     r_ovf <= 1'b0;
    end

    assign w_head     = w_empty ? '0 : w_rdata;
    assign UART_RDATA = w_head[E_DATA_MSB:E_DATA_LSB];
    assign PERR       = w_head[E_PERR];
    assign FERR       = w_head[E_FERR];
    assign BRK        = w_head[E_BRK];
    assign RXRDY      = ~w_empty;
    assign OVF        = r_ovf;
    assign FIFO_COUNT = w_count;

endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
// Self-checking bench: frame-level reference model (queue of expected entries
// with scheduled push cycles) compared against the DUT every cycle.
module tb_uart_rx_fifo_engine;

    localparam int unsigned K_W   = 20;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [K_W-1:0]   K;
    logic [K_W-1:0]   K_2;
    logic             RX_in;
    logic             EIGHT;
    logic             PEN;
    logic             OHEL;
    logic             TWO_STOP;
    logic             READS;
    logic [7:0]       UART_RDATA;
    logic             RXRDY;
    logic             PERR;
    logic             FERR;
    logic             BRK;
    logic             OVF;
    logic [CNT_W-1:0] FIFO_COUNT;

    always #5 clk = ~clk;

    uart_rx_fifo_engine #(
        .K_W        (K_W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .K          (K),
        .K_2        (K_2),
        .RX_in      (RX_in),
        .EIGHT      (EIGHT),
        .PEN        (PEN),
        .OHEL       (OHEL),
        .TWO_STOP   (TWO_STOP),
        .READS      (READS),
        .UART_RDATA (UART_RDATA),
        .RXRDY      (RXRDY),
        .PERR       (PERR),
        .FERR       (FERR),
        .BRK        (BRK),
        .OVF        (OVF),
        .FIFO_COUNT (FIFO_COUNT)
    );

    typedef struct {
        int unsigned cyc;
        logic [10:0] e;
    } sched_t;

    sched_t      sched[$];
    logic [10:0] mq[$];
    bit          m_ovf;
    int unsigned cyc;
    int unsigned vectors;
    int unsigned miscompares;
    int unsigned printed;
    bit          checking;
    bit          rand_reads;
    int unsigned read_thresh;
    int unsigned kb;
    int unsigned k2b;
    bit          mp_do;
    logic [10:0] mp_e;
    logic [10:0] hexp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (printed < 60) begin
                printed++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
            end
        end
    endtask

    // Reference model: entries appear at their scheduled cycle; reads pop first.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            sched.delete();
            m_ovf = 1'b0;
        end else begin
            mp_do = 1'b0;
            mp_e  = '0;
            if (sched.size() > 0 && sched[0].cyc == cyc) begin
                mp_do = 1'b1;
                mp_e  = sched[0].e;
                void'(sched.pop_front());
            end
            if (READS && mq.size() > 0) void'(mq.pop_front());
            if (READS) m_ovf = 1'b0;
            if (mp_do) begin
                if (mq.size() < DEPTH) mq.push_back(mp_e);
                else                   m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            hexp = (mq.size() > 0) ? mq[0] : 11'h000;
            check("RXRDY",      32'(RXRDY),      32'(mq.size() != 0));
            check("FIFO_COUNT", 32'(FIFO_COUNT), 32'(mq.size()));
            check("OVF",        32'(OVF),        32'(m_ovf));
            check("UART_RDATA", 32'(UART_RDATA), 32'(hexp[7:0]));
            check("PERR",       32'(PERR),       32'(hexp[8]));
            check("FERR",       32'(FERR),       32'(hexp[9]));
            check("BRK",        32'(BRK),        32'(hexp[10]));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_reads) READS = ($urandom_range(0, 999) < read_thresh);
        end
    end

    task automatic set_baud(input int unsigned k);
        kb  = k;
        k2b = k / 2;
        K   = K_W'(kb);
        K_2 = K_W'(k2b);
    endtask

    task automatic drive_bit(input logic b);
        RX_in = b;
        repeat (kb) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit eight, input bit pen, input bit odd,
                              input bit two, input bit pbit, input bit stop1, input bit stop2,
                              input bit scramble);
        int unsigned nd;
        int unsigned nb;
        int unsigned ones;
        int unsigned s;
        logic [7:0]  dm;
        bit          perr;
        bit          ferr;
        bit          brk;
        nd   = eight ? 8 : 7;
        dm   = eight ? d : {1'b0, d[6:0]};
        nb   = nd + (pen ? 1 : 0) + 1 + (two ? 1 : 0);
        ones = $countones(dm) + (pbit ? 1 : 0);
        perr = pen && (odd ? (ones % 2 == 0) : (ones % 2 == 1));
        ferr = !stop1 || (two && !stop2);
        brk  = (dm == 8'h00) && (!pen || !pbit) && !stop1;
        @(posedge clk);
        #1;
        EIGHT = eight; PEN = pen; OHEL = odd; TWO_STOP = two;
        s = cyc;
        // Last frame bit is sampled mid-bit 3+K/2 clocks in; entry lands one clock later.
        sched.push_back('{s + 4 + k2b + kb * nb, {brk, ferr, perr, dm}});
        drive_bit(1'b0);
        if (scramble) begin
            EIGHT = 1'($urandom); PEN = 1'($urandom); OHEL = 1'($urandom); TWO_STOP = 1'($urandom);
        end
        for (int unsigned i = 0; i < nd; i++) drive_bit(dm[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop1);
        if (two) drive_bit(stop2);
        RX_in = 1'b1;
    endtask

    task automatic pulse_read();
        @(posedge clk);
        #1 READS = 1'b1;
        @(posedge clk);
        #1 READS = 1'b0;
        @(negedge clk);
    endtask

    int unsigned s0;

    initial begin
        reset = 1'b1; RX_in = 1'b1; READS = 1'b0;
        EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; TWO_STOP = 1'b0;
        set_baud(16);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check("reset RXRDY", 32'(RXRDY), 32'd0);
        check("reset FIFO_COUNT", 32'(FIFO_COUNT), 32'd0);
        check("reset OVF", 32'(OVF), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // 0xA5 8N1: RXRDY rises exactly two clocks after the stop-bit BTU.
        fork
            send_frame(8'hA5, 1, 0, 0, 0, 0, 1, 1, 0);
            begin
                @(posedge clk);
                #1;
                repeat (155) @(posedge clk);
                @(negedge clk);
                check("rxrdy before push", 32'(RXRDY), 32'd0);
                @(negedge clk);
                check("rxrdy at push", 32'(RXRDY), 32'd1);
            end
        join
        @(negedge clk);
        check("A5 data", 32'(UART_RDATA), 32'hA5);
        check("A5 flags", 32'({BRK, FERR, PERR}), 32'd0);
        check("A5 count", 32'(FIFO_COUNT), 32'd1);
        pulse_read();
        check("A5 popped", 32'(RXRDY), 32'd0);

        // 7O1: 0x41 with good then bad parity bit.
        send_frame(8'h41, 0, 1, 1, 0, 1, 1, 1, 0);
        repeat (3) @(posedge clk);
        send_frame(8'h41, 0, 1, 1, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("7O1 data", 32'(UART_RDATA), 32'h41);
        check("7O1 perr good", 32'(PERR), 32'd0);
        pulse_read();
        check("7O1 perr bad", 32'(PERR), 32'd1);
        pulse_read();

        // Short low glitch is a false start; then a frame with a bad stop bit.
        @(posedge clk);
        #1 RX_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 RX_in = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch count", 32'(FIFO_COUNT), 32'd0);
        send_frame(8'h3C, 1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("3C ferr", 32'(FERR), 32'd1);
        check("3C brk", 32'(BRK), 32'd0);
        pulse_read();

        // Line held low for 30 bit times: one break entry, then 0x55 after idle.
        @(posedge clk);
        #1;
        s0 = cyc;
        sched.push_back('{s0 + 4 + k2b + kb * 9, 11'h600});
        RX_in = 1'b0;
        repeat (30 * kb) @(posedge clk);
        #1 RX_in = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("break count", 32'(FIFO_COUNT), 32'd1);
        check("break brk/ferr", 32'({BRK, FERR}), 32'd3);
        check("break data", 32'(UART_RDATA), 32'h00);
        send_frame(8'h55, 1, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        pulse_read();
        check("after break data", 32'(UART_RDATA), 32'h55);
        pulse_read();

        // Overrun: five frames with no reads, then a push with a coincident read.
        for (int unsigned i = 0; i < 5; i++) begin
            send_frame(8'(8'h10 + i), 1, 0, 0, 0, 0, 1, 1, 0);
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        check("ovf count", 32'(FIFO_COUNT), 32'd4);
        check("ovf set", 32'(OVF), 32'd1);
        check("ovf head", 32'(UART_RDATA), 32'h10);
        fork
            send_frame(8'h99, 1, 0, 0, 0, 0, 1, 1, 0);
            begin
                @(posedge clk);
                #1;
                repeat (155) @(posedge clk);
                #1 READS = 1'b1;
                @(posedge clk);
                #1 READS = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full+read count", 32'(FIFO_COUNT), 32'd4);
        check("full+read ovf", 32'(OVF), 32'd0);
        check("full+read head", 32'(UART_RDATA), 32'h11);
        repeat (3) pulse_read();
        check("tail frame", 32'(UART_RDATA), 32'h99);
        pulse_read();

        // Reset in the middle of DATA with a non-empty FIFO.
        send_frame(8'h5A, 1, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 RX_in = 1'b0;
        repeat (3 * kb) @(posedge clk);
        #1 RX_in = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst data", 32'(UART_RDATA), 32'd0);
        check("rst rxrdy", 32'(RXRDY), 32'd0);
        check("rst count", 32'(FIFO_COUNT), 32'd0);
        check("rst flags", 32'({BRK, FERR, PERR, OVF}), 32'd0);
        repeat (4) @(posedge clk);
        send_frame(8'hC3, 1, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post-reset data", 32'(UART_RDATA), 32'hC3);
        pulse_read();

        // Randomised frames, configurations, baud rates and read traffic.
        for (int unsigned n = 0; n < 40; n++) begin
            logic [7:0] d;
            set_baud($urandom_range(10, 24));
            case ($urandom_range(0, 3))
                0:       read_thresh = 0;
                1:       read_thresh = 3;
                2:       read_thresh = 20;
                default: read_thresh = 250;
            endcase
            rand_reads = 1'b1;
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 1'b1);
            repeat ($urandom_range(2, kb)) @(posedge clk);
            #1;
        end
        rand_reads = 1'b0;
        @(posedge clk);
        #2 READS = 1'b0;
        repeat (2 * DEPTH) pulse_read();
        repeat (10) @(posedge clk);
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
